mips_mmio: RTL and testbench
============================

MIPS_MMIO -- requirements
Module: mips_mmio

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per UART bit (legal 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port memaddr  input  32  CPU data address.
REQ-006 SHALL have port memwrite  input  1  CPU store strobe.
REQ-007 SHALL have port memwritedata  input  32  CPU store data.
REQ-008 SHALL have port mmiosel  output  1  memaddr[31:8] == 24'hFFFF00 (combinational).
REQ-009 SHALL have port mmioreaddata  output  32  register read data, combinational from memaddr[7:0]; 0 when mmiosel=0 or offset unmapped.
REQ-010 SHALL have port txd  output  1  UART serial out, idle high.
REQ-011 SHALL have port irq  output  1  timer match interrupt level.

Function
REQ-012 SHALL accept a register write on the clock edge where memwrite=1 and mmiosel=1; reads SHALL have zero latency (single-cycle CPU).
REQ-013 SHALL map offsets: 0x00 TCNT (RW), 0x04 TCMP (RW), 0x08 TCTRL (bit0 en RW, bit1 match W1C), 0x10 UTX (WO, byte memwritedata[7:0]), 0x14 USTAT (bit0 full, bit1 empty, bit2 overflow W1C, bit3 busy; RO otherwise).
REQ-014 SHALL increment TCNT by 1 per cycle while en=1, wrapping 32'hFFFFFFFF -> 0.
REQ-015 SHALL set match on the cycle TCNT==TCMP with en=1; a CPU write to TCNT SHALL take priority over that cycle's increment.
REQ-016 SHALL drive irq = match; W1C of match in the same cycle as a new match SHALL leave match set.
REQ-017 SHALL push UTX writes into the FIFO; write to a full FIFO SHALL drop the byte and set overflow, unless the serializer pops in the same cycle, in which case the byte SHALL be accepted.
REQ-018 SHALL run serializer states IDLE -> START -> DATA -> STOP -> IDLE, each bit held CLKS_PER_BIT cycles, DATA LSB-first 8 bits, 8N1 framing.
REQ-019 SHALL pop the FIFO in IDLE when non-empty, START beginning the next cycle; back-to-back bytes SHALL have no idle gap after STOP.
REQ-020 SHALL report busy=1 whenever state != IDLE; reads of UTX SHALL return 0.

Reset
REQ-021 SHALL on reset=0, immediately: TCNT=0, TCMP=32'hFFFFFFFF, en=0, match=0, irq=0, FIFO empty, overflow=0, state IDLE, txd=1, bit counters 0.
REQ-022 SHALL abort any frame in progress on reset (txd high at once, byte lost); deassertion SHALL be the only event needed to resume.

Configuration
REQ-023 SHALL compile the timer only when macro MIPS_MMIO_TIMER_EN is defined.
REQ-024 SHALL, without MIPS_MMIO_TIMER_EN, read 0 at 0x00/0x04/0x08, ignore writes there, tie irq=0; UART unaffected.

Structure
REQ-025 SHALL place base address 24'hFFFF00, register offsets, USTAT/TCTRL bit indices and the UART state enum in shared package mmio_pkg.
REQ-026 SHALL implement the serializer as sub-module uart_tx (inputs byte+valid, outputs ready, txd, busy); FIFO and timer stay in mips_mmio.

Verification
REQ-027 Store 0x41 to 0xFFFF0010, CLKS_PER_BIT=4 -> txd: 4 cycles 0, bits 1,0,0,0,0,0,1,0 each 4 cycles, 4 cycles 1; busy 1 throughout.
REQ-028 Five UTX stores in 5 consecutive cycles while idle, depth 4 -> all 5 transmitted (first popped before fifth arrives), overflow=0; sixth store with FIFO full -> dropped, USTAT bit2=1, W1C clears it.
REQ-029 TCMP=5, TCTRL=1, TCNT=0 -> irq rises when TCNT reaches 5, stays high; write TCTRL=0x3 -> irq low next cycle.
REQ-030 TCNT=32'hFFFFFFFE, en=1 -> reads FFFFFFFF then 0 then 1.
REQ-031 reset=0 mid-DATA bit -> txd=1 same cycle, USTAT=0x2 after release, subsequent store transmits a clean frame.
REQ-032 Build without MIPS_MMIO_TIMER_EN: write 0x1234 to 0xFFFF0000 -> read 0, irq 0; read of 0xFFFF0020 or memaddr 0x00000010 -> mmioreaddata 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared MMIO definitions: base address, register offsets, bit indices, UART states.
`timescale 1ns/1ps
package mmio_pkg;

    localparam logic [23:0] MMIO_BASE = 24'hFFFF00;

    localparam logic [7:0] OFF_TCNT  = 8'h00;
    localparam logic [7:0] OFF_TCMP  = 8'h04;
    localparam logic [7:0] OFF_TCTRL = 8'h08;
    localparam logic [7:0] OFF_UTX   = 8'h10;
    localparam logic [7:0] OFF_USTAT = 8'h14;

    localparam int unsigned TCTRL_EN_BIT    = 0;
    localparam int unsigned TCTRL_MATCH_BIT = 1;

    localparam int unsigned USTAT_FULL_BIT  = 0;
    localparam int unsigned USTAT_EMPTY_BIT = 1;
    localparam int unsigned USTAT_OVF_BIT   = 2;
    localparam int unsigned USTAT_BUSY_BIT  = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // USTAT payload; member order matches the USTAT_*_BIT indices (full at bit 0).
    typedef struct packed {
        logic busy;
        logic overflow;
        logic empty;
        logic full;
    } ustat_t;

    function automatic logic [31:0] pack_ustat(input ustat_t s);
        return {28'd0, s};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serializer; accepts a new byte at the end of STOP so frames run back to back.
`timescale 1ns/1ps
module uart_tx
    import mmio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitidx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (cnt == LAST);
    assign ready   = (state == UART_IDLE) || ((state == UART_STOP) && bit_end);
    assign busy    = (state != UART_IDLE);

    // Frame sequencer: bit timing, shift register and the registered line output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= UART_IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shreg  <= '0;
            txd    <= 1'b1;
        end else begin
            case (state)
                UART_IDLE: begin
                    cnt <= '0;
                    if (valid) begin
                        shreg <= data;
                        txd   <= 1'b0;
                        state <= UART_START;
                    end
                end
                UART_START: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        bitidx <= '0;
                        txd    <= shreg[0];
                        state  <= UART_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                UART_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bitidx == 3'd7) begin
                            bitidx <= '0;
                            txd    <= 1'b1;
                            state  <= UART_STOP;
                        end else begin
                            bitidx <= bitidx + 3'd1;
                            shreg  <= {1'b0, shreg[7:1]};
                            txd    <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                UART_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (valid) begin
                            shreg <= data;
                            txd   <= 1'b0;
                            state <= UART_START;
                        end else begin
                            state <= UART_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= UART_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_mmio.sv
// MMIO block for a single-cycle MIPS: UART TX with FIFO, plus an optional
// compare-match timer built only when MIPS_MMIO_TIMER_EN is defined.
`timescale 1ns/1ps
module mips_mmio
    import mmio_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic        memwrite,
    input  logic [31:0] memwritedata,
    output logic        mmiosel,
    output logic [31:0] mmioreaddata,
    output logic        txd,
    output logic        irq
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]  offset;
    logic        wr_en;
    logic        utx_wr;
    logic        ustat_wr;

    assign offset   = memaddr[7:0];
    assign mmiosel  = (memaddr[31:8] == MMIO_BASE);
    assign wr_en    = memwrite && mmiosel;
    assign utx_wr   = wr_en && (offset == OFF_UTX);
    assign ustat_wr = wr_en && (offset == OFF_USTAT);

    // ---------------- TX FIFO ----------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          overflow;
    logic          tx_ready;
    logic          tx_busy;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign pop   = tx_ready && !empty;
    // A pop in the same cycle frees a slot, so a store to a full FIFO still lands.
    assign push  = utx_wr && (!full || pop);

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= memwritedata[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Sticky overflow flag: set by a dropped store, cleared by W1C; set wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (utx_wr && full && !pop) begin
            overflow <= 1'b1;
        end else if (ustat_wr && memwritedata[USTAT_OVF_BIT]) begin
            overflow <= 1'b0;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .reset(reset),
        .data (mem[rptr]),
        .valid(!empty),
        .ready(tx_ready),
        .txd  (txd),
        .busy (tx_busy)
    );

    ustat_t ustat;
    assign ustat = '{busy: tx_busy, overflow: overflow, empty: empty, full: full};

    // ---------------- Timer ----------------
    logic [31:0] timer_rd;

`ifdef MIPS_MMIO_TIMER_EN
    logic [31:0] tcnt;
    logic [31:0] tcmp;
    logic        ten;
    logic        match;
    logic        tcnt_wr;
    logic        tcmp_wr;
    logic        tctrl_wr;
    logic        match_hit;

    assign tcnt_wr   = wr_en && (offset == OFF_TCNT);
    assign tcmp_wr   = wr_en && (offset == OFF_TCMP);
    assign tctrl_wr  = wr_en && (offset == OFF_TCTRL);
    assign match_hit = ten && (tcnt == tcmp);

    // Counter, compare and control; a CPU write to TCNT overrides the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt  <= '0;
            tcmp  <= 32'hFFFF_FFFF;
            ten   <= 1'b0;
            match <= 1'b0;
        end else begin
            if (tcnt_wr)  tcnt <= memwritedata;
            else if (ten) tcnt <= tcnt + 32'd1;
            if (tcmp_wr)  tcmp <= memwritedata;
            if (tctrl_wr) ten  <= memwritedata[TCTRL_EN_BIT];
            if (match_hit) match <= 1'b1;
            else if (tctrl_wr && memwritedata[TCTRL_MATCH_BIT]) match <= 1'b0;
        end
    end

    assign irq = match;

    // Timer register read mux.
    always_comb begin
        timer_rd = '0;
        case (offset)
            OFF_TCNT:  timer_rd = tcnt;
            OFF_TCMP:  timer_rd = tcmp;
            OFF_TCTRL: timer_rd = {30'd0, match, ten};
            default:   timer_rd = '0;
        endcase
    end
`else
    logic unused_wdata;
    assign unused_wdata = ^memwritedata[31:8];
    assign irq          = 1'b0;
    assign timer_rd     = '0;
`endif

    // Zero-latency register read; unmapped offsets and non-MMIO addresses read 0.
    always_comb begin
        mmioreaddata = '0;
        if (mmiosel) begin
            case (offset)
                OFF_TCNT, OFF_TCMP, OFF_TCTRL: mmioreaddata = timer_rd;
                OFF_USTAT:                     mmioreaddata = pack_ustat(ustat);
                default:                       mmioreaddata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mmio.sv
// Directed bench for mips_mmio: register decode table plus UART/timer sequences.
// Works with or without MIPS_MMIO_TIMER_EN.
`timescale 1ns/1ps
module tb_mips_mmio;

`ifdef MIPS_MMIO_TIMER_EN
    localparam bit TIM = 1'b1;
`else
    localparam bit TIM = 1'b0;
`endif

    localparam int CPB  = 4;
    localparam int BITC = 10 * CPB;

    localparam logic [31:0] A_TCNT  = 32'hFFFF_0000;
    localparam logic [31:0] A_TCMP  = 32'hFFFF_0004;
    localparam logic [31:0] A_TCTRL = 32'hFFFF_0008;
    localparam logic [31:0] A_UTX   = 32'hFFFF_0010;
    localparam logic [31:0] A_USTAT = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] memaddr = '0;
    logic        memwrite = 1'b0;
    logic [31:0] memwritedata = '0;
    logic        mmiosel;
    logic [31:0] mmioreaddata;
    logic        txd;
    logic        irq;

    mips_mmio #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memaddr     (memaddr),
        .memwrite    (memwrite),
        .memwritedata(memwritedata),
        .mmiosel     (mmiosel),
        .mmioreaddata(mmioreaddata),
        .txd         (txd),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit   rec = 1'b0;
    logic txq[$];
    always @(negedge clk) if (rec) txq.push_back(txd);

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memaddr      = a;
        memwritedata = d;
        memwrite     = 1'b1;
        @(negedge clk);
        memwrite     = 1'b0;
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        memaddr = a;
        #1;
        chk(name, mmioreaddata, exp);
    endtask

    function automatic logic exp_txd(input logic [7:0] b, input int i);
        logic [7:0] bb;
        bb = b;
        if (i < CPB) return 1'b0;
        if (i < 9 * CPB) return bb[3'((i - CPB) / CPB)];
        return 1'b1;
    endfunction

    // Called at the negedge right after the UTX store edge, with the serializer idle.
    task automatic check_frame(input logic [7:0] b);
        rdchk("frame_pending_ustat", A_USTAT, 32'h0);
        @(negedge clk);
        for (int i = 0; i < BITC; i++) begin
            chk($sformatf("frame_%02h_txd_%0d", b, i), {31'd0, txd}, {31'd0, exp_txd(b, i)});
            memaddr = A_USTAT;
            #1;
            chk($sformatf("frame_%02h_busy_%0d", b, i), {31'd0, mmioreaddata[3]}, 32'd1);
            @(negedge clk);
        end
        chk("frame_end_txd", {31'd0, txd}, 32'd1);
        rdchk("frame_end_ustat", A_USTAT, 32'h2);
    endtask

    initial begin
        logic [7:0] b;
        int s;
        int zeros;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Decode/register table: read checks reflect state before this row's write edge
        vt[0]  = '{1'b0, A_USTAT,       32'h0,        1'b1, 32'h2};
        vt[1]  = '{1'b0, A_UTX,         32'h0,        1'b1, 32'h0};
        vt[2]  = '{1'b0, 32'hFFFF_0020, 32'h0,        1'b1, 32'h0};
        vt[3]  = '{1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'h0};
        vt[4]  = '{1'b0, 32'hFFFE_0014, 32'h0,        1'b0, 32'h0};
        vt[5]  = '{1'b0, A_TCNT,        32'h0,        1'b1, 32'h0};
        vt[6]  = '{1'b0, A_TCMP,        32'h0,        1'b1, TIM ? 32'hFFFF_FFFF : 32'h0};
        vt[7]  = '{1'b0, A_TCTRL,       32'h0,        1'b1, 32'h0};
        vt[8]  = '{1'b1, A_TCMP,        32'h1234_5678, 1'b1, TIM ? 32'hFFFF_FFFF : 32'h0};
        vt[9]  = '{1'b0, A_TCMP,        32'h0,        1'b1, TIM ? 32'h1234_5678 : 32'h0};
        vt[10] = '{1'b1, A_TCNT,        32'h0000_1234, 1'b1, 32'h0};
        vt[11] = '{1'b1, 32'h0000_0000, 32'h0000_00AA, 1'b0, 32'h0};
        vt[12] = '{1'b0, A_TCNT,        32'h0,        1'b1, TIM ? 32'h0000_1234 : 32'h0};
        vt[13] = '{1'b1, 32'h0000_0010, 32'h0000_0055, 1'b0, 32'h0};
        vt[14] = '{1'b0, A_USTAT,       32'h0,        1'b1, 32'h2};
        for (int i = 0; i < 15; i++) begin
            memaddr      = vt[i].addr;
            memwritedata = vt[i].wdata;
            memwrite     = vt[i].we;
            #1;
            chk($sformatf("tbl%0d_sel", i), {31'd0, mmiosel}, {31'd0, vt[i].exp_sel});
            chk($sformatf("tbl%0d_rd", i), mmioreaddata, vt[i].exp_rd);
            @(negedge clk);
            memwrite = 1'b0;
        end

        // Single frame, 0x41
        wr(A_UTX, 32'h41);
        check_frame(8'h41);

        // Five back-to-back stores, sixth dropped, overflow W1C
        txq.delete();
        rec = 1'b1;
        for (int k = 0; k < 5; k++) wr(A_UTX, 32'(8'h11 + k));
        rdchk("b_full_no_ovf", A_USTAT, 32'h9);
        wr(A_UTX, 32'h16);
        rdchk("b_ovf_set", A_USTAT, 32'hD);
        wr(A_USTAT, 32'h4);
        rdchk("b_ovf_clr", A_USTAT, 32'h9);
        for (int g = 0; g < 400 && txq.size() < 240; g++) @(negedge clk);
        rec = 1'b0;
        chk("b_record_len", {31'd0, txq.size() >= 240}, 32'd1);
        if (txq.size() >= 240) begin
            s = -1;
            for (int i = 0; i < 20; i++) if (s < 0 && txq[i] == 1'b0) s = i;
            chk("b_first_start", {31'd0, s >= 0}, 32'd1);
            if (s < 0) s = 0;
            for (int f = 0; f < 5; f++) begin
                chk($sformatf("b_f%0d_start", f), {31'd0, txq[s + BITC*f + 2]}, 32'd0);
                for (int j = 0; j < 8; j++) b[j] = txq[s + BITC*f + CPB + CPB*j + 2];
                chk($sformatf("b_f%0d_byte", f), {24'd0, b}, 32'(8'h11 + f));
                chk($sformatf("b_f%0d_stop", f), {31'd0, txq[s + BITC*f + 9*CPB + 2]}, 32'd1);
            end
            zeros = 0;
            for (int i = s + 5*BITC; i < txq.size(); i++) if (txq[i] == 1'b0) zeros++;
            chk("b_no_sixth_frame", 32'(zeros), 32'd0);
        end
        rdchk("b_final_ustat", A_USTAT, 32'h2);

        // Reset in the middle of a data bit
        wr(A_UTX, 32'hA5);
        repeat (10) @(negedge clk);
        chk("c_pre_txd", {31'd0, txd}, 32'd0);
        rdchk("c_pre_ustat", A_USTAT, 32'hA);
        #2;
        reset = 1'b0;
        #1;
        chk("c_async_txd", {31'd0, txd}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        rdchk("c_post_ustat", A_USTAT, 32'h2);
        chk("c_post_irq", {31'd0, irq}, 32'd0);
        wr(A_UTX, 32'h3C);
        check_frame(8'h3C);

`ifdef MIPS_MMIO_TIMER_EN
        // Compare match, W1C racing a new match, clear, wrap
        wr(A_TCMP, 32'd5);
        wr(A_TCTRL, 32'd1);
        wr(A_TCNT, 32'd0);
        for (int i = 0; i < 10; i++) begin
            rdchk($sformatf("t_cnt_%0d", i), A_TCNT, 32'(i));
            chk($sformatf("t_irq_%0d", i), {31'd0, irq}, {31'd0, i >= 6});
            @(negedge clk);
        end
        rdchk("t_tctrl_match", A_TCTRL, 32'h3);
        wr(A_TCMP, 32'd11);
        wr(A_TCTRL, 32'h3);
        chk("t_w1c_vs_match", {31'd0, irq}, 32'd1);
        wr(A_TCTRL, 32'h3);
        chk("t_w1c_clear", {31'd0, irq}, 32'd0);
        rdchk("t_tctrl_after", A_TCTRL, 32'h1);
        wr(A_TCNT, 32'hFFFF_FFFE);
        rdchk("t_wrap0", A_TCNT, 32'hFFFF_FFFE);
        @(negedge clk);
        rdchk("t_wrap1", A_TCNT, 32'hFFFF_FFFF);
        @(negedge clk);
        rdchk("t_wrap2", A_TCNT, 32'h0);
        @(negedge clk);
        rdchk("t_wrap3", A_TCNT, 32'h1);
        wr(A_TCTRL, 32'h0);
        rdchk("t_hold0", A_TCNT, 32'h2);
        @(negedge clk);
        rdchk("t_hold1", A_TCNT, 32'h2);
`else
        // Timer absent: writes ignored, reads 0, irq tied low
        wr(A_TCNT, 32'h1234);
        wr(A_TCTRL, 32'h1);
        wr(A_TCMP, 32'h0);
        rdchk("nt_tcnt", A_TCNT, 32'h0);
        rdchk("nt_tcmp", A_TCMP, 32'h0);
        rdchk("nt_tctrl", A_TCTRL, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("nt_irq_%0d", i), {31'd0, irq}, 32'd0);
            @(negedge clk);
        end
        rdchk("nt_unmapped", 32'hFFFF_0020, 32'h0);
        rdchk("nt_nonmmio", 32'h0000_0010, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
